// File: rtl/sq_circular_queue_pkg.sv
// Shared types for the LSU store queue: entry/packet layouts and core-wide widths.
package rv32i_types;

  localparam int LSQ_DEPTH    = 8;
  localparam int PHYS_WIDTH   = 6;
  localparam int ROB_ID_WIDTH = 5;

  typedef struct packed {
    logic [ROB_ID_WIDTH-1:0] rob_id;
    logic [PHYS_WIDTH-1:0]   rs1_paddr;
    logic [PHYS_WIDTH-1:0]   rs2_paddr;
    logic [31:0]             imm;
    logic [2:0]              funct3;
  } sq_entry;

  typedef struct packed {
    logic [ROB_ID_WIDTH-1:0] rob_id;
    logic [PHYS_WIDTH-1:0]   rs1_paddr;
    logic [PHYS_WIDTH-1:0]   rs2_paddr;
    logic [31:0]             imm;
    logic [2:0]              funct3;
  } sq_pkt;

endpackage

// File: rtl/sq_circular_queue.sv
// In-order store queue: allocates from dispatch, issues the head store once its
// operands are ready and it is the ROB head, and exports occupancy to the load queue.
module sq_circular_queue
  import rv32i_types::*;
#(
  parameter int  DEPTH      = LSQ_DEPTH,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             br_flush,
  input  logic                             enable,
  input  sq_entry                          st_entry_in,
  output logic                             sq_full,
  output logic                             sq_empty,
  output logic [DEPTH-1:0][PHYS_WIDTH-1:0] rs1_out,
  output logic [DEPTH-1:0][PHYS_WIDTH-1:0] rs2_out,
  input  logic [DEPTH-1:0]                 rs1_valid,
  input  logic [DEPTH-1:0]                 rs2_valid,
  input  logic [ROB_ID_WIDTH-1:0]          rob_head_id,
  input  logic                             rob_head_valid,
  output logic                             st_req_valid,
  input  logic                             st_req_ready,
  output sq_pkt                            st_pkt_out,
  output logic                             store_inserted,
  output logic [ADDR_WIDTH-1:0]            store_inserted_index,
  output logic                             store_selected,
  output logic [ADDR_WIDTH-1:0]            store_selected_index,
  output logic [DEPTH-1:0]                 store_valid
);

  // Extra MSB is the wrap bit that separates full from empty.
  typedef logic [ADDR_WIDTH:0] ptr_t;

  ptr_t                  head;
  ptr_t                  tail;
  logic [DEPTH-1:0]      valid;
  sq_entry               queue [DEPTH];

  logic [ADDR_WIDTH-1:0] head_idx;
  logic [ADDR_WIDTH-1:0] tail_idx;
  sq_entry               head_entry;
  logic                  flush;
  logic                  full;
  logic                  empty;
  logic                  head_ready;
  logic                  do_alloc;
  logic                  do_issue;

  assign head_idx   = head[ADDR_WIDTH-1:0];
  assign tail_idx   = tail[ADDR_WIDTH-1:0];
  assign head_entry = queue[head_idx];
  assign flush      = rst | br_flush;

  assign full  = (head[ADDR_WIDTH-1:0] == tail[ADDR_WIDTH-1:0]) &&
                 (head[ADDR_WIDTH] != tail[ADDR_WIDTH]);
  assign empty = (head == tail);

  assign head_ready = valid[head_idx] & rs1_valid[head_idx] & rs2_valid[head_idx] &
                      rob_head_valid & (rob_head_id == head_entry.rob_id);

  assign st_req_valid = head_ready & ~flush;
  assign do_issue     = st_req_valid & st_req_ready;
  // A slot freed by issue becomes allocatable only next cycle, since full is registered.
  assign do_alloc     = enable & ~full & ~flush;

  assign sq_full              = full;
  assign sq_empty             = empty;
  assign store_valid          = valid;
  assign store_inserted       = do_alloc;
  assign store_inserted_index = tail_idx;
  assign store_selected       = do_issue;
  assign store_selected_index = head_idx;

  assign st_pkt_out.rob_id    = head_entry.rob_id;
  assign st_pkt_out.rs1_paddr = head_entry.rs1_paddr;
  assign st_pkt_out.rs2_paddr = head_entry.rs2_paddr;
  assign st_pkt_out.imm       = head_entry.imm;
  assign st_pkt_out.funct3    = head_entry.funct3;

  for (genvar i = 0; i < DEPTH; i++) begin : g_tags
    assign rs1_out[i] = queue[i].rs1_paddr;
    assign rs2_out[i] = queue[i].rs2_paddr;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (flush) begin
      head  <= '0;
      tail  <= '0;
      valid <= '0;
    end else begin
      if (do_alloc) begin
        valid[tail_idx] <= 1'b1;
        tail            <= tail + ptr_t'(1);
      end
      if (do_issue) begin
        valid[head_idx] <= 1'b0;
        head            <= head + ptr_t'(1);
      end
    end
  end

  // NOTE: the payload array is deliberately not reset; the valid bits qualify every read.
  always_ff @(posedge clk) begin
    if (do_alloc) queue[tail_idx] <= st_entry_in;
  end

endmodule

// File: tb/tb_sq_circular_queue.sv
// Directed plus randomized bench for sq_circular_queue against an in-order queue model.
module tb_sq_circular_queue;
  import rv32i_types::*;

  localparam int DEPTH = LSQ_DEPTH;
  localparam int AW    = $clog2(DEPTH);

  logic                             clk = 1'b0;
  logic                             rst;
  logic                             br_flush;
  logic                             enable;
  sq_entry                          st_entry_in;
  logic                             sq_full;
  logic                             sq_empty;
  logic [DEPTH-1:0][PHYS_WIDTH-1:0] rs1_out;
  logic [DEPTH-1:0][PHYS_WIDTH-1:0] rs2_out;
  logic [DEPTH-1:0]                 rs1_valid;
  logic [DEPTH-1:0]                 rs2_valid;
  logic [ROB_ID_WIDTH-1:0]          rob_head_id;
  logic                             rob_head_valid;
  logic                             st_req_valid;
  logic                             st_req_ready;
  sq_pkt                            st_pkt_out;
  logic                             store_inserted;
  logic [AW-1:0]                    store_inserted_index;
  logic                             store_selected;
  logic [AW-1:0]                    store_selected_index;
  logic [DEPTH-1:0]                 store_valid;

  sq_circular_queue dut (
    .clk(clk), .rst(rst), .br_flush(br_flush), .enable(enable),
    .st_entry_in(st_entry_in), .sq_full(sq_full), .sq_empty(sq_empty),
    .rs1_out(rs1_out), .rs2_out(rs2_out), .rs1_valid(rs1_valid), .rs2_valid(rs2_valid),
    .rob_head_id(rob_head_id), .rob_head_valid(rob_head_valid),
    .st_req_valid(st_req_valid), .st_req_ready(st_req_ready), .st_pkt_out(st_pkt_out),
    .store_inserted(store_inserted), .store_inserted_index(store_inserted_index),
    .store_selected(store_selected), .store_selected_index(store_selected_index),
    .store_valid(store_valid)
  );

  always #5 clk = ~clk;

  // Reference model: stores in program order plus free-running allocate/issue counts.
  sq_entry model_q[$];
  int      head_ptr = 0;
  int      tail_ptr = 0;
  int      checks   = 0;
  int      failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic sq_entry mk(input int rob);
    sq_entry e;
    e.rob_id    = ROB_ID_WIDTH'(rob);
    e.rs1_paddr = PHYS_WIDTH'($urandom_range(63, 0));
    e.rs2_paddr = PHYS_WIDTH'($urandom_range(63, 0));
    e.imm       = $urandom;
    e.funct3    = 3'($urandom_range(7, 0));
    return e;
  endfunction

  function automatic logic [DEPTH-1:0] rand_bits();
    logic [31:0] r;
    r = $urandom | $urandom;
    return r[DEPTH-1:0];
  endfunction

  // Checks the current cycle against the model, then advances one clock edge.
  task automatic step(input bit do_check);
    int               n;
    int               hslot;
    int               tslot;
    bit               flush_e;
    bit               exp_req;
    bit               exp_alloc;
    bit               exp_issue;
    logic [DEPTH-1:0] exp_sv;
    #2;
    n       = model_q.size();
    hslot   = head_ptr % DEPTH;
    tslot   = tail_ptr % DEPTH;
    flush_e = rst || br_flush;
    exp_req = 1'b0;
    if (n > 0)
      exp_req = !flush_e && rs1_valid[hslot] && rs2_valid[hslot] && rob_head_valid &&
                (rob_head_id == model_q[0].rob_id);
    exp_alloc = enable && (n < DEPTH) && !flush_e;
    exp_issue = exp_req && st_req_ready;
    exp_sv    = '0;
    for (int k = 0; k < n; k++) exp_sv[(head_ptr + k) % DEPTH] = 1'b1;

    if (do_check) begin
      check("sq_empty", sq_empty, n == 0);
      check("sq_full", sq_full, n == DEPTH);
      check("store_valid", store_valid, exp_sv);
      check("st_req_valid", st_req_valid, exp_req);
      check("store_inserted", store_inserted, exp_alloc);
      check("store_selected", store_selected, exp_issue);
      if (exp_alloc) check("store_inserted_index", store_inserted_index, tslot);
      if (exp_issue) check("store_selected_index", store_selected_index, hslot);
      if (exp_req)   check("st_pkt_out", st_pkt_out, model_q[0]);
      for (int k = 0; k < n; k++) begin
        check("rs1_out", rs1_out[(head_ptr + k) % DEPTH], model_q[k].rs1_paddr);
        check("rs2_out", rs2_out[(head_ptr + k) % DEPTH], model_q[k].rs2_paddr);
      end
    end

    @(posedge clk);
    if (flush_e) begin
      model_q.delete();
      head_ptr = 0;
      tail_ptr = 0;
    end else begin
      if (exp_issue) begin
        void'(model_q.pop_front());
        head_ptr = (head_ptr + 1) % (2 * DEPTH);
      end
      if (exp_alloc) begin
        model_q.push_back(st_entry_in);
        tail_ptr = (tail_ptr + 1) % (2 * DEPTH);
      end
    end
    #1;
  endtask

  task automatic flush_once();
    br_flush = 1'b1;
    step(1);
    br_flush = 1'b0;
  endtask

  initial begin
    rst = 1'b1; br_flush = 1'b0; enable = 1'b0; st_entry_in = mk(0);
    rs1_valid = '0; rs2_valid = '0; rob_head_id = '0; rob_head_valid = 1'b0;
    st_req_ready = 1'b0;

    // Reset: first edge establishes state, then check it while still in reset.
    step(0);
    step(1);
    rst = 1'b0;
    step(1);

    // Single store, operands not ready.
    enable = 1'b1; st_entry_in = mk(3);
    step(1);
    enable = 1'b0;
    step(1);

    // Operands ready and ROB head matches: issue from slot 0.
    rs1_valid = '1; rs2_valid = '1; rob_head_id = 5'd3; rob_head_valid = 1'b1;
    st_req_ready = 1'b1;
    step(1);
    st_req_ready = 1'b0;
    step(1);

    // Fill to full, drop a ninth, then issue+enable together and wrap the tail.
    flush_once();
    rob_head_valid = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      enable = 1'b1; st_entry_in = mk(8 + i);
      step(1);
    end
    st_entry_in = mk(20);
    step(1);
    rob_head_valid = 1'b1; rob_head_id = 5'd8; st_req_ready = 1'b1;
    step(1);
    st_req_ready = 1'b0;
    step(1);
    enable = 1'b0;
    step(1);

    // Head ready but memory stalls for three cycles, then accepts.
    rob_head_id = 5'd9;
    for (int i = 0; i < 3; i++) step(1);
    st_req_ready = 1'b1;
    step(1);
    st_req_ready = 1'b0;

    // Flush beats a simultaneous allocate and issue.
    flush_once();
    rob_head_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      enable = 1'b1; st_entry_in = mk(1 + i);
      step(1);
    end
    rob_head_valid = 1'b1; rob_head_id = 5'd1; st_req_ready = 1'b1;
    st_entry_in = mk(6); br_flush = 1'b1;
    step(1);
    br_flush = 1'b0; enable = 1'b0; st_req_ready = 1'b0;
    step(1);
    enable = 1'b1; st_entry_in = mk(7);
    step(1);
    enable = 1'b0;

    // Wrong ROB head holds the store back.
    flush_once();
    enable = 1'b1; st_entry_in = mk(5);
    step(1);
    enable = 1'b0; rob_head_id = 5'd4; st_req_ready = 1'b1;
    step(1);
    step(1);
    rob_head_id = 5'd5;
    step(1);
    st_req_ready = 1'b0;

    // Randomized traffic including flushes and mid-run resets.
    for (int i = 0; i < 800; i++) begin
      enable         = ($urandom_range(2, 0) != 0);
      st_entry_in    = mk($urandom_range(31, 0));
      st_req_ready   = ($urandom_range(1, 0) != 0);
      br_flush       = ($urandom_range(29, 0) == 0);
      rst            = ($urandom_range(99, 0) == 0);
      rs1_valid      = rand_bits();
      rs2_valid      = rand_bits();
      rob_head_valid = ($urandom_range(3, 0) != 0);
      if (model_q.size() > 0 && $urandom_range(2, 0) != 0) rob_head_id = model_q[0].rob_id;
      else rob_head_id = ROB_ID_WIDTH'($urandom_range(31, 0));
      step(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sq_circular_queue.md
Name: sq_circular_queue

Overview:
- In-order store queue for the OoO core's LSU; it is the store-side partner of the load queue.
- Accepts stores from dispatch and tracks operand readiness through PRF ready bits.
- Issues the head store to the data-memory path only when its operands are ready and it is at the ROB head.
- Drives the store-dependency interface (store_valid, store_inserted, store_selected plus indices) that the load queue uses to order loads behind older stores.

Parameters:
- DEPTH, LSQ_DEPTH (8): number of store entries; must be a power of two.
- ADDR_WIDTH, $clog2(DEPTH) (localparam): entry index width.
- PHYS_WIDTH, package value (6): physical register index width.
- ROB_ID_WIDTH, package value (5): ROB tag width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- br_flush  in  1  squash all entries
- enable  in  1  dispatch presents a store
- st_entry_in  in  sq_entry  rob_id, rs1_paddr, rs2_paddr, imm[31:0], funct3[2:0]
- sq_full  out  1  no free entry
- sq_empty  out  1  no valid entry
- rs1_out  out  PHYS_WIDTH x DEPTH  per-entry base-register tag, sent to the PRF ready lookup
- rs2_out  out  PHYS_WIDTH x DEPTH  per-entry data-register tag
- rs1_valid  in  1 x DEPTH  ready bit for rs1_out[i]
- rs2_valid  in  1 x DEPTH  ready bit for rs2_out[i]
- rob_head_id  in  ROB_ID_WIDTH  tag of the oldest ROB entry
- rob_head_valid  in  1  rob_head_id is meaningful
- st_req_valid  out  1  store packet offered to memory stage
- st_req_ready  in  1  memory stage accepts
- st_pkt_out  out  sq_pkt  rob_id, rs1_paddr, rs2_paddr, imm, funct3 of the head entry
- store_inserted  out  1  store allocated this cycle
- store_inserted_index  out  ADDR_WIDTH  slot allocated
- store_selected  out  1  store issued this cycle
- store_selected_index  out  ADDR_WIDTH  slot issued
- store_valid  out  DEPTH  registered occupancy bitmap

Behaviour:
- Reset is rst, synchronous, active-high, on clock clk. Reset clears head, tail and all valid bits, so sq_empty=1, sq_full=0, store_valid=0, st_req_valid=0, store_inserted=0, store_selected=0.
- head and tail are ADDR_WIDTH+1 bits; the MSB is a wrap bit.
  - full = low bits equal and MSBs differ.
  - empty = head==tail.
  - Both are decoded from registered pointers only.
- Allocate: when enable && !sq_full, the entry is written at tail[ADDR_WIDTH-1:0] and its valid bit set on the next edge; tail increments.
  - store_inserted=1 and store_inserted_index=tail low bits, both combinational in the same cycle.
  - enable while full is ignored with no state change; dispatch must hold the store.
- Issue is strictly from head and is combinational: st_req_valid = head valid && rs1_valid[head] && rs2_valid[head] && rob_head_valid && rob_head_id==queue[head].rob_id && !br_flush.
- st_pkt_out always shows the head entry; its content is don't-care when st_req_valid=0.
- Handshake completes when st_req_valid && st_req_ready. In that cycle:
  - store_selected=1 and store_selected_index=head low bits (combinational);
  - the head valid bit clears and head increments on the next edge.
- st_req_valid, once raised, must not drop while st_req_ready=0, except on br_flush.
- store_valid[i] is the registered valid bit of entry i. It does not reflect same-cycle insert or issue; the load queue combines it with store_inserted and store_selected.
- Allocate and issue in the same cycle are both performed. When full, issue frees a slot only from the next cycle onward; there is no same-cycle bypass.
- br_flush takes priority over allocate and issue:
  - st_req_valid and store_selected are forced to 0;
  - store_inserted is forced to 0;
  - head, tail and all valid bits are cleared on the edge.
- rst asserted mid-operation behaves identically to br_flush.
- Pointer wrap: tail passing DEPTH-1 returns to index 0 with the MSB toggled. Indices reported on store_*_index are the low bits only.

Decomposition:
- Shared rv32i_types package holds:
  - sq_entry and sq_pkt structs;
  - LSQ_DEPTH, PHYS_WIDTH and ROB_ID_WIDTH constants.
- A single flat module is used; no sub-module is required.

Test Plan:
- Reset, then insert 1 store (rob_id=3) with rs1_valid=rs2_valid=0 -> store_inserted=1, index 0; next cycle store_valid=8'b0000_0001, sq_empty=0, st_req_valid=0.
- Make operands ready with rob_head_id=3 and st_req_ready=1 -> st_req_valid=1, store_selected=1, index 0; next cycle store_valid=0, sq_empty=1.
- Fill 8 stores -> sq_full=1; a 9th enable is dropped. Issue one and insert in the same cycle -> the new store lands at index 0 only after the slot frees, and tail wraps with MSB=1.
- Head ready with st_req_ready=0 for 3 cycles -> st_req_valid held at 1, store_selected=0, packet stable; on the ready cycle -> selected=1.
- 4 valid entries, br_flush asserted together with enable and a ready head -> store_inserted=0, store_selected=0; next cycle store_valid=0, head==tail==0.
- Head rob_id=5, rob_head_id=4, operands ready -> st_req_valid=0 until rob_head_id=5.
